// File: rtl/complex_iq_pkg.sv
// complex_iq_pkg: shared widths, op-type encodings and the issue-queue
// entry record for the div/mod complex issue queue.
`ifndef ROB_ENTRY_INDEX_WIDTH
`define ROB_ENTRY_INDEX_WIDTH 6
`endif
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 6
`endif
`ifndef GENERAL_OPTYPE_3R
`define GENERAL_OPTYPE_3R 4'd2
`endif
`ifndef _3R_DIV
`define _3R_DIV 5'd0
`endif
`ifndef _3R_MOD
`define _3R_MOD 5'd1
`endif
`ifndef _3R_DIVU
`define _3R_DIVU 5'd2
`endif
`ifndef _3R_MODU
`define _3R_MODU 5'd3
`endif

package complex_iq_pkg;
   localparam int ROB_W = `ROB_ENTRY_INDEX_WIDTH;
   localparam int PREG_W = `PREG_INDEX_WIDTH;
   localparam int IQ_DEPTH_DEFAULT = 8;

   typedef struct packed {
      logic              valid;
      logic [3:0]        gen_op;
      logic [4:0]        spec_op;
      logic [ROB_W-1:0]  rob;
      logic [PREG_W-1:0] rd;
      logic [PREG_W-1:0] rj;
      logic [PREG_W-1:0] rk;
      logic              rj_rdy;
      logic              rk_rdy;
   } complex_iq_entry_t;
endpackage

// File: rtl/complex_iq_select.sv
// complex_iq_select: combinational lowest-index priority picker.
// Ports: i_req (per-entry request), o_grant_valid, o_grant_index.
module complex_iq_select #(
   parameter int DEPTH = 8,
   parameter int IW = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] i_req,
   output logic             o_grant_valid,
   output logic [IW-1:0]    o_grant_index
);
   // Scan high to low so the lowest requester wins last.
   always_comb begin
      o_grant_valid = 1'b0;
      o_grant_index = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_grant_valid = 1'b1;
            o_grant_index = IW'(i);
         end
      end
   end
endmodule

// File: rtl/complex_iq.sv
// complex_iq: compacting issue queue for the div/mod unit (entry 0 oldest).
// Ports: clk/rst/flush, dispatch_* in, wakeup_* in, IQ_valid/FU_ready
// issue handshake, issued op fields out. Macro COMPLEX_IQ_PERF_EN adds
// perf_issue_cnt / perf_full_cnt outputs.
module complex_iq
   import complex_iq_pkg::*;
#(
   parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT,
   parameter int WAKEUP_PORTS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           dispatch_valid,
   output logic                           dispatch_ready,
   input  logic [3:0]                     dispatch_gen_op_type,
   input  logic [4:0]                     dispatch_spec_op_type,
   input  logic [ROB_W-1:0]               dispatch_rob_entry_index,
   input  logic [PREG_W-1:0]              dispatch_preg_rd_index,
   input  logic [PREG_W-1:0]              dispatch_preg_rj_index,
   input  logic [PREG_W-1:0]              dispatch_preg_rk_index,
   input  logic                           dispatch_rj_ready,
   input  logic                           dispatch_rk_ready,
   input  logic [WAKEUP_PORTS-1:0]        wakeup_valid,
   input  logic [WAKEUP_PORTS*PREG_W-1:0] wakeup_preg_index,
   output logic                           IQ_valid,
   input  logic                           FU_ready,
   output logic [3:0]                     gen_op_type,
   output logic [4:0]                     spec_op_type,
   output logic [ROB_W-1:0]               rob_entry_index,
   output logic [PREG_W-1:0]              preg_rd_index,
   output logic [PREG_W-1:0]              preg_rj_index,
   output logic [PREG_W-1:0]              preg_rk_index
`ifdef COMPLEX_IQ_PERF_EN
  ,output logic [31:0]                    perf_issue_cnt,
   output logic [31:0]                    perf_full_cnt
`endif
);
   localparam int CW = $clog2(IQ_DEPTH + 1);
   localparam int IW = $clog2(IQ_DEPTH);

   complex_iq_entry_t r_q   [IQ_DEPTH];
   complex_iq_entry_t w_ext [IQ_DEPTH+1];
   complex_iq_entry_t w_nq  [IQ_DEPTH];
   complex_iq_entry_t w_new;
   logic [CW-1:0]       r_count, w_ncount, w_slot;
   logic [IQ_DEPTH-1:0] w_req;
   logic                w_gv, w_fire, w_disp;
   logic [IW-1:0]       w_gi;

   function automatic logic f_hit(input logic [PREG_W-1:0] tag);
      f_hit = 1'b0;
      for (int p = 0; p < WAKEUP_PORTS; p++)
         if (wakeup_valid[p] && wakeup_preg_index[p*PREG_W +: PREG_W] == tag)
            f_hit = 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < IQ_DEPTH; i++)
         w_req[i] = r_q[i].valid & r_q[i].rj_rdy & r_q[i].rk_rdy;
   end

   complex_iq_select #(.DEPTH(IQ_DEPTH), .IW(IW)) u_sel (
      .i_req         (w_req),
      .o_grant_valid (w_gv),
      .o_grant_index (w_gi)
   );

   assign dispatch_ready  = (r_count < CW'(IQ_DEPTH)) && !flush;
   assign IQ_valid        = w_gv && !flush;
   assign w_fire          = IQ_valid && FU_ready;
   assign w_disp          = dispatch_valid && dispatch_ready;
   assign gen_op_type     = IQ_valid ? r_q[w_gi].gen_op  : '0;
   assign spec_op_type    = IQ_valid ? r_q[w_gi].spec_op : '0;
   assign rob_entry_index = IQ_valid ? r_q[w_gi].rob     : '0;
   assign preg_rd_index   = IQ_valid ? r_q[w_gi].rd      : '0;
   assign preg_rj_index   = IQ_valid ? r_q[w_gi].rj      : '0;
   assign preg_rk_index   = IQ_valid ? r_q[w_gi].rk      : '0;

   // Next state: compact over the fired slot, wake in post-shift position,
   // then drop the dispatched op at the first free slot.
   always_comb begin
      for (int i = 0; i < IQ_DEPTH; i++)
         w_ext[i] = r_q[i];
      w_ext[IQ_DEPTH] = '0;

      w_new         = '0;
      w_new.valid   = 1'b1;
      w_new.gen_op  = dispatch_gen_op_type;
      w_new.spec_op = dispatch_spec_op_type;
      w_new.rob     = dispatch_rob_entry_index;
      w_new.rd      = dispatch_preg_rd_index;
      w_new.rj      = dispatch_preg_rj_index;
      w_new.rk      = dispatch_preg_rk_index;
      w_new.rj_rdy  = dispatch_rj_ready || (dispatch_preg_rj_index == '0) ||
                      f_hit(dispatch_preg_rj_index);
      w_new.rk_rdy  = dispatch_rk_ready || (dispatch_preg_rk_index == '0) ||
                      f_hit(dispatch_preg_rk_index);

      w_slot = w_fire ? r_count - CW'(1) : r_count;

      for (int i = 0; i < IQ_DEPTH; i++) begin
         w_nq[i] = (w_fire && (i >= int'(w_gi))) ? w_ext[i+1] : w_ext[i];
         if (w_nq[i].valid) begin
            if (f_hit(w_nq[i].rj)) w_nq[i].rj_rdy = 1'b1;
            if (f_hit(w_nq[i].rk)) w_nq[i].rk_rdy = 1'b1;
         end
         if (w_disp && (CW'(i) == w_slot))
            w_nq[i] = w_new;
      end

      w_ncount = r_count + CW'(w_disp) - CW'(w_fire);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < IQ_DEPTH; i++)
            r_q[i] <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < IQ_DEPTH; i++)
            r_q[i] <= w_nq[i];
         r_count <= w_ncount;
      end
   end

`ifdef COMPLEX_IQ_PERF_EN
   logic [31:0] r_issue_cnt, r_full_cnt;

   // Counters survive flush; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue_cnt <= '0;
         r_full_cnt  <= '0;
      end else begin
         if (w_fire)
            r_issue_cnt <= r_issue_cnt + 32'd1;
         if ((r_count == CW'(IQ_DEPTH)) && dispatch_valid)
            r_full_cnt <= r_full_cnt + 32'd1;
      end
   end

   assign perf_issue_cnt = r_issue_cnt;
   assign perf_full_cnt  = r_full_cnt;
`endif
endmodule

// File: tb/tb_complex_iq.sv
// tb_complex_iq: random + directed stimulus against a queue-based
// reference model of complex_iq.
module tb_complex_iq;
   import complex_iq_pkg::*;
   localparam int D  = 8;
   localparam int WP = 4;
   localparam int PW = PREG_W;
   localparam int RW = ROB_W;

   logic clk = 1'b0;
   logic rst, flush, dispatch_valid, dispatch_ready;
   logic [3:0] dispatch_gen_op_type;
   logic [4:0] dispatch_spec_op_type;
   logic [RW-1:0] dispatch_rob_entry_index;
   logic [PW-1:0] dispatch_preg_rd_index, dispatch_preg_rj_index;
   logic [PW-1:0] dispatch_preg_rk_index;
   logic dispatch_rj_ready, dispatch_rk_ready;
   logic [WP-1:0] wakeup_valid;
   logic [WP*PW-1:0] wakeup_preg_index;
   logic IQ_valid, FU_ready;
   logic [3:0] gen_op_type;
   logic [4:0] spec_op_type;
   logic [RW-1:0] rob_entry_index;
   logic [PW-1:0] preg_rd_index, preg_rj_index, preg_rk_index;
`ifdef COMPLEX_IQ_PERF_EN
   logic [31:0] perf_issue_cnt, perf_full_cnt;
`endif

   complex_iq #(.IQ_DEPTH(D), .WAKEUP_PORTS(WP)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_gen_op_type(dispatch_gen_op_type),
      .dispatch_spec_op_type(dispatch_spec_op_type),
      .dispatch_rob_entry_index(dispatch_rob_entry_index),
      .dispatch_preg_rd_index(dispatch_preg_rd_index),
      .dispatch_preg_rj_index(dispatch_preg_rj_index),
      .dispatch_preg_rk_index(dispatch_preg_rk_index),
      .dispatch_rj_ready(dispatch_rj_ready),
      .dispatch_rk_ready(dispatch_rk_ready),
      .wakeup_valid(wakeup_valid), .wakeup_preg_index(wakeup_preg_index),
      .IQ_valid(IQ_valid), .FU_ready(FU_ready),
      .gen_op_type(gen_op_type), .spec_op_type(spec_op_type),
      .rob_entry_index(rob_entry_index),
      .preg_rd_index(preg_rd_index), .preg_rj_index(preg_rj_index),
      .preg_rk_index(preg_rk_index)
`ifdef COMPLEX_IQ_PERF_EN
     ,.perf_issue_cnt(perf_issue_cnt), .perf_full_cnt(perf_full_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vec = 0;
   int errs = 0;

   complex_iq_entry_t mq[$];
   logic [31:0] m_issue, m_full;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic hit(input logic [PW-1:0] tag);
      for (int p = 0; p < WP; p++)
         if (wakeup_valid[p] && wakeup_preg_index[p*PW +: PW] == tag)
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic idle();
      dispatch_valid = 0; flush = 0; rst = 0; FU_ready = 0;
      dispatch_gen_op_type = 0; dispatch_spec_op_type = 0;
      dispatch_rob_entry_index = 0; dispatch_preg_rd_index = 0;
      dispatch_preg_rj_index = 0; dispatch_preg_rk_index = 0;
      dispatch_rj_ready = 0; dispatch_rk_ready = 0;
      wakeup_valid = 0; wakeup_preg_index = 0;
   endtask

   task automatic set_disp(input logic [4:0] sp, input int rob, input int rd,
                           input int rj, input int rk,
                           input logic rjr, input logic rkr);
      dispatch_valid = 1;
      dispatch_gen_op_type = `GENERAL_OPTYPE_3R;
      dispatch_spec_op_type = sp;
      dispatch_rob_entry_index = RW'(rob);
      dispatch_preg_rd_index = PW'(rd);
      dispatch_preg_rj_index = PW'(rj);
      dispatch_preg_rk_index = PW'(rk);
      dispatch_rj_ready = rjr;
      dispatch_rk_ready = rkr;
   endtask

   task automatic wake(input int port, input int tag);
      wakeup_valid[port] = 1'b1;
      wakeup_preg_index[port*PW +: PW] = PW'(tag);
   endtask

   // Called just after a negedge with inputs set: compare, clock, model.
   task automatic step();
      int cand;
      logic exp_iv, exp_dr, fire;
      complex_iq_entry_t e, n;
      #1;
      cand = -1;
      foreach (mq[i])
         if (cand < 0 && mq[i].rj_rdy && mq[i].rk_rdy) cand = i;
      exp_iv = (cand >= 0) && !flush;
      exp_dr = (mq.size() < D) && !flush;
      e = exp_iv ? mq[cand] : '0;
      chk("dispatch_ready", dispatch_ready, exp_dr);
      chk("IQ_valid", IQ_valid, exp_iv);
      chk("gen_op_type", gen_op_type, e.gen_op);
      chk("spec_op_type", spec_op_type, e.spec_op);
      chk("rob_entry_index", rob_entry_index, e.rob);
      chk("preg_rd_index", preg_rd_index, e.rd);
      chk("preg_rj_index", preg_rj_index, e.rj);
      chk("preg_rk_index", preg_rk_index, e.rk);
`ifdef COMPLEX_IQ_PERF_EN
      chk("perf_issue_cnt", perf_issue_cnt, m_issue);
      chk("perf_full_cnt", perf_full_cnt, m_full);
`endif
      @(posedge clk);
      fire = exp_iv && FU_ready;
      if (rst) begin
         mq.delete(); m_issue = 0; m_full = 0;
      end else begin
         if (fire) m_issue++;
         if (mq.size() == D && dispatch_valid) m_full++;
         if (flush) mq.delete();
         else begin
            if (fire) mq.delete(cand);
            foreach (mq[i]) begin
               if (hit(mq[i].rj)) mq[i].rj_rdy = 1;
               if (hit(mq[i].rk)) mq[i].rk_rdy = 1;
            end
            if (dispatch_valid && exp_dr) begin
               n = '0;
               n.valid = 1;
               n.gen_op = dispatch_gen_op_type;
               n.spec_op = dispatch_spec_op_type;
               n.rob = dispatch_rob_entry_index;
               n.rd = dispatch_preg_rd_index;
               n.rj = dispatch_preg_rj_index;
               n.rk = dispatch_preg_rk_index;
               n.rj_rdy = dispatch_rj_ready || n.rj == 0 || hit(n.rj);
               n.rk_rdy = dispatch_rk_ready || n.rk == 0 || hit(n.rk);
               mq.push_back(n);
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      mq.delete(); m_issue = 0; m_full = 0;
      @(negedge clk);
      step();

      // Basic issue: DIV rob 3 rd 10, both ready.
      idle(); set_disp(`_3R_DIV, 3, 10, 5, 6, 1, 1); FU_ready = 1;
      #1 chk("t1_rdy_after_rst", dispatch_ready, 1);
      chk("t1_iv_empty", IQ_valid, 0);
      step();
      idle(); FU_ready = 1;
      #1 chk("t1_iv", IQ_valid, 1);
      chk("t1_rob", rob_entry_index, 3);
      chk("t1_rd", preg_rd_index, 10);
      step();
      idle();
      #1 chk("t1_iv_after_fire", IQ_valid, 0);
      step();

      // Wakeup latency: MOD with rj=7 not ready.
      idle(); set_disp(`_3R_MOD, 4, 11, 7, 0, 0, 0);
      step();
      idle(); step();
      idle(); step();
      idle(); wake(2, 7);
      #1 chk("t2_iv_wake_cycle", IQ_valid, 0);
      step();
      idle(); FU_ready = 1;
      #1 chk("t2_iv_after_wake", IQ_valid, 1);
      chk("t2_rob", rob_entry_index, 4);
      step();

      // Ordering under backpressure.
      idle(); set_disp(`_3R_DIVU, 1, 12, 0, 0, 1, 1); step();
      idle(); set_disp(`_3R_MODU, 2, 13, 0, 0, 1, 1); step();
      for (int c = 0; c < 4; c++) begin
         idle();
         #1 chk("t3_hold_rob", rob_entry_index, 1);
         step();
      end
      idle(); FU_ready = 1;
      #1 chk("t3_first", rob_entry_index, 1);
      step();
      idle(); FU_ready = 1;
      #1 chk("t3_second", rob_entry_index, 2);
      step();

      // Fill to full with not-ready ops.
      for (int k = 0; k < D; k++) begin
         idle(); set_disp(`_3R_DIV, 16 + k, 1, 20 + k, 0, 0, 0); step();
      end
      idle(); set_disp(`_3R_DIV, 40, 1, 2, 0, 1, 1);
      #1 chk("t4_full_rdy", dispatch_ready, 0);
      step();
      idle(); wake(1, 23); step();
      idle(); FU_ready = 1; set_disp(`_3R_DIV, 41, 2, 0, 0, 1, 1);
      #1 chk("t4_full_fire_rdy", dispatch_ready, 0);
      chk("t4_fire_rob", rob_entry_index, 19);
      step();
      idle(); set_disp(`_3R_DIV, 41, 2, 0, 0, 1, 1);
      #1 chk("t4_accept_after", dispatch_ready, 1);
      step();
      idle();
      #1 chk("t4_full_again", dispatch_ready, 0);
      step();
      idle(); flush = 1; step();

      // Same-cycle wakeup at dispatch.
      idle(); set_disp(`_3R_MOD, 9, 14, 9, 0, 0, 0); wake(0, 9); step();
      idle(); FU_ready = 1;
      #1 chk("t5_iv", IQ_valid, 1);
      chk("t5_rob", rob_entry_index, 9);
      step();

      // Flush with 5 queued.
      for (int k = 0; k < 5; k++) begin
         idle(); set_disp(`_3R_DIV, 50 + k, 3, 0, 0, 1, 1); step();
      end
      idle(); flush = 1;
      #1 chk("t6_iv_flush", IQ_valid, 0);
      step();
      idle();
      #1 chk("t6_rdy_after", dispatch_ready, 1);
      chk("t6_iv_after", IQ_valid, 0);
      step();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         idle();
         if ($urandom_range(99) < 60)
            set_disp(5'($urandom_range(3)), int'($urandom_range(63)),
                     int'($urandom_range(15)), int'($urandom_range(15)),
                     int'($urandom_range(15)), 1'($urandom_range(3) == 0),
                     1'($urandom_range(3) == 0));
         for (int p = 0; p < WP; p++)
            if ($urandom_range(99) < 30) wake(p, int'($urandom_range(15)));
         FU_ready = 1'($urandom_range(1));
         flush = ($urandom_range(99) < 2);
         rst = ($urandom_range(999) < 5);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
